// File: rtl/prbs_stream_checker_if.sv
// prbs_stream_checker_if: AXI-Stream word channel between a PRBS source and the checker
interface prbs_stream_checker_if;
    logic [31:0] tdata;
    logic        tvalid;
    logic        tready;
    modport master (output tdata, tvalid, input tready);
    modport slave  (input tdata, tvalid, output tready);
endinterface

// File: rtl/prbs_stream_checker.sv
// prbs_stream_checker: self-synchronising PRBS31 word checker with lock FSM and saturating error counters
module prbs_stream_checker #(
    parameter int CODEWORD_SIZE_IN_32 = 65,
    parameter bit INV_PATTERN         = 1'b1,
    parameter int LOCK_COUNT          = 16,
    parameter int UNLOCK_COUNT        = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    prbs_stream_checker_if.slave s_axis,
    input  logic                 clear_cnt,
    output logic                 locked,
    output logic                 err_valid,
    output logic [31:0]          err_vec,
    output logic [47:0]          word_cnt,
    output logic [31:0]          err_word_cnt,
    output logic [31:0]          err_bit_cnt,
    output logic [31:0]          cw_err_cnt
);
    typedef enum logic {HUNT, LOCKED} state_t;
    state_t      state_q, state_d;
    logic        ready_q, seed_q, ev_q, mark_q, mark_d;
    logic        accept, err, last, lock_now, count;
    logic [31:0] prev_q, vec_q, exp_w;
    logic [63:0] seq;
    logic [7:0]  match_q, match_d, miss_q, miss_d;
    logic [15:0] idx_q, idx_d;
    logic [5:0]  pop;
    logic [47:0] wc_q, wc_d;
    logic [31:0] ewc_q, ewc_d, ebc_q, ebc_d, cwe_q, cwe_d;

    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[32] ? '1 : s[31:0];
    endfunction

    assign accept = s_axis.tvalid && ready_q;

    // Bit j+31/j+28 of {prev, expected} are the n-31/n-28 taps; prev[31] is never reached.
    always_comb begin
        seq = {prev_q, 32'd0};
        for (int j = 31; j >= 0; j--) seq[j] = seq[j + 31] ^ seq[j + 28] ^ INV_PATTERN;
        exp_w = seq[31:0];
    end

    always_comb begin
        pop = '0;
        for (int i = 0; i < 32; i++) pop = pop + 6'(vec_q[i]);
    end

    always_comb begin
        err      = vec_q != '0;
        last     = idx_q == 16'(CODEWORD_SIZE_IN_32 - 1);
        lock_now = state_q == HUNT && ev_q && !err && match_q == 8'(LOCK_COUNT - 1);
        count    = ev_q && (state_q == LOCKED || lock_now);
        state_d  = state_q;
        match_d  = match_q;
        miss_d   = miss_q;
        idx_d    = idx_q;
        mark_d   = mark_q;
        cwe_d    = cwe_q;
        if (ev_q && state_q == HUNT) begin
            match_d = err ? '0 : match_q + 8'd1;
            if (lock_now) begin
                state_d = LOCKED;
                miss_d  = '0;
                idx_d   = '0;
                mark_d  = 1'b0;
            end
        end else if (ev_q) begin
            miss_d = err ? miss_q + 8'd1 : '0;
            idx_d  = last ? '0 : idx_q + 16'd1;
            mark_d = !last && (mark_q || err);
            cwe_d  = last && (mark_q || err) ? sat_add(cwe_q, 32'd1) : cwe_q;
            if (err && miss_q == 8'(UNLOCK_COUNT - 1)) begin
                state_d = HUNT;
                match_d = '0;
                idx_d   = '0;
                mark_d  = 1'b0;
            end
        end
        wc_d  = clear_cnt ? '0 : count ? wc_q + 48'd1 : wc_q;
        ewc_d = clear_cnt ? '0 : count && err ? sat_add(ewc_q, 32'd1) : ewc_q;
        ebc_d = clear_cnt ? '0 : count && err ? sat_add(ebc_q, 32'(pop)) : ebc_q;
        cwe_d = clear_cnt ? '0 : cwe_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ready_q <= 1'b0;
            seed_q  <= 1'b0;
            ev_q    <= 1'b0;
            prev_q  <= '0;
            vec_q   <= '0;
            state_q <= HUNT;
            match_q <= '0;
            miss_q  <= '0;
            idx_q   <= '0;
            mark_q  <= 1'b0;
            wc_q    <= '0;
            ewc_q   <= '0;
            ebc_q   <= '0;
            cwe_q   <= '0;
        end else begin
            ready_q <= 1'b1;
            ev_q    <= accept && seed_q;
            if (accept) begin
                prev_q <= s_axis.tdata;
                seed_q <= 1'b1;
            end
            if (accept && seed_q) vec_q <= s_axis.tdata ^ exp_w;
            state_q <= state_d;
            match_q <= match_d;
            miss_q  <= miss_d;
            idx_q   <= idx_d;
            mark_q  <= mark_d;
            wc_q    <= wc_d;
            ewc_q   <= ewc_d;
            ebc_q   <= ebc_d;
            cwe_q   <= cwe_d;
        end
    end

    assign s_axis.tready = ready_q;
    assign locked        = state_q == LOCKED || lock_now;
    assign err_valid     = ev_q;
    assign err_vec       = vec_q;
    assign word_cnt      = wc_q;
    assign err_word_cnt  = ewc_q;
    assign err_bit_cnt   = ebc_q;
    assign cw_err_cnt    = cwe_q;
endmodule

// File: tb/tb_prbs_stream_checker.sv
// tb_prbs_stream_checker: directed scenarios against a serial PRBS31 source model
module tb_prbs_stream_checker;
    logic        clk = 1'b0;
    logic        rst, clear_cnt, locked, err_valid;
    logic [31:0] err_vec, err_word_cnt, err_bit_cnt, cw_err_cnt;
    logic [47:0] word_cnt;
    logic [30:0] hist;
    int          checks = 0;
    int          fails = 0;

    prbs_stream_checker_if axis();

    prbs_stream_checker dut (
        .clk(clk), .rst(rst), .s_axis(axis), .clear_cnt(clear_cnt), .locked(locked),
        .err_valid(err_valid), .err_vec(err_vec), .word_cnt(word_cnt),
        .err_word_cnt(err_word_cnt), .err_bit_cnt(err_bit_cnt), .cw_err_cnt(cw_err_cnt)
    );

    always #5 clk = ~clk;

    // hist[0] is the newest bit; inverted PRBS31 s[n] = ~(s[n-31] ^ s[n-28])
    task automatic gen(output logic [31:0] w);
        logic b;
        for (int i = 0; i < 32; i++) begin
            b = ~(hist[30] ^ hist[27]);
            hist = {hist[29:0], b};
            w = {w[30:0], b};
        end
    endtask

    task automatic drive(input logic [31:0] d);
        axis.tdata = d;
        axis.tvalid = 1'b1;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        axis.tvalid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_clear();
        axis.tvalid = 1'b0;
        clear_cnt = 1'b1;
        @(negedge clk);
        clear_cnt = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_cnt = 1'b0;
        axis.tvalid = 1'b0;
        axis.tdata = '0;
        repeat (3) @(negedge clk);
        checks++; if (axis.tready !== 1'b0) begin fails++; $display("FAIL reset_tready: got %b want 0", axis.tready); end
        checks++; if ({locked, err_valid} !== 2'b00) begin fails++; $display("FAIL reset_flags: got %b want 00", {locked, err_valid}); end
        checks++; if (err_vec !== 32'd0) begin fails++; $display("FAIL reset_err_vec: got %h want 0", err_vec); end
        checks++; if ({word_cnt, err_word_cnt, err_bit_cnt, cw_err_cnt} !== '0) begin fails++; $display("FAIL reset_counters: got %h want 0", {word_cnt, err_word_cnt, err_bit_cnt, cw_err_cnt}); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (axis.tready !== 1'b1) begin fails++; $display("FAIL ready_after_reset: got %b want 1", axis.tready); end
    endtask

    task automatic test_clean_lock();
        logic [31:0] w;
        int lock_at = -1;
        int bad = 0;
        hist = 31'h1;
        for (int i = 0; i < 200; i++) begin
            gen(w);
            drive(w);
            if (i == 0) begin
                checks++; if (err_valid !== 1'b0) begin fails++; $display("FAIL seed_no_err_valid: got %b want 0", err_valid); end
            end else if (err_valid !== 1'b1 || err_vec !== 32'd0) bad++;
            if (locked === 1'b1 && lock_at < 0) lock_at = i;
        end
        checks++; if (bad !== 0) begin fails++; $display("FAIL clean_err_vec: got %0d bad words want 0", bad); end
        checks++; if (lock_at !== 16) begin fails++; $display("FAIL clean_lock_word: got %0d want 16", lock_at); end
        idle(1);
        checks++; if (word_cnt !== 48'd184) begin fails++; $display("FAIL clean_word_cnt: got %0d want 184", word_cnt); end
        checks++; if ({err_word_cnt, err_bit_cnt, cw_err_cnt} !== '0) begin fails++; $display("FAIL clean_err_counters: got %h want 0", {err_word_cnt, err_bit_cnt, cw_err_cnt}); end
    endtask

    task automatic test_early_bit();
        logic [31:0] w;
        for (int i = 0; i < 5; i++) begin gen(w); drive(w); end
        gen(w);
        drive(w ^ 32'h8000_0000);
        checks++; if (err_valid !== 1'b1 || err_vec !== 32'h8000_0000) begin fails++; $display("FAIL early_err_vec: got %b/%h want 1/80000000", err_valid, err_vec); end
        gen(w);
        drive(w);
        checks++; if (err_vec !== 32'd0) begin fails++; $display("FAIL early_no_propagation: got %h want 0", err_vec); end
        idle(1);
        checks++; if (err_word_cnt !== 32'd1 || err_bit_cnt !== 32'd1) begin fails++; $display("FAIL early_counts: got %0d/%0d want 1/1", err_word_cnt, err_bit_cnt); end
        checks++; if (cw_err_cnt !== 32'd0) begin fails++; $display("FAIL early_cw_pending: got %0d want 0", cw_err_cnt); end
        for (int i = 0; i < 70; i++) begin gen(w); drive(w); end
        idle(1);
        checks++; if (cw_err_cnt !== 32'd1) begin fails++; $display("FAIL early_cw_closed: got %0d want 1", cw_err_cnt); end
        checks++; if (locked !== 1'b1) begin fails++; $display("FAIL early_locked: got %b want 1", locked); end
    endtask

    task automatic test_late_bit();
        logic [31:0] w;
        pulse_clear();
        checks++; if ({word_cnt, err_word_cnt, err_bit_cnt, cw_err_cnt} !== '0) begin fails++; $display("FAIL clear_counters: got %h want 0", {word_cnt, err_word_cnt, err_bit_cnt, cw_err_cnt}); end
        gen(w);
        drive(w ^ 32'h1);
        checks++; if (err_vec !== 32'h0000_0001) begin fails++; $display("FAIL late_err_vec: got %h want 00000001", err_vec); end
        gen(w);
        drive(w);
        checks++; if (err_vec !== 32'h0000_0012) begin fails++; $display("FAIL late_propagated: got %h want 00000012", err_vec); end
        gen(w);
        drive(w);
        checks++; if (err_vec !== 32'd0) begin fails++; $display("FAIL late_settled: got %h want 0", err_vec); end
        idle(1);
        checks++; if (err_word_cnt !== 32'd2 || err_bit_cnt !== 32'd3) begin fails++; $display("FAIL late_counts: got %0d/%0d want 2/3", err_word_cnt, err_bit_cnt); end
        checks++; if (word_cnt !== 48'd3 || locked !== 1'b1) begin fails++; $display("FAIL late_words_locked: got %0d/%b want 3/1", word_cnt, locked); end
    endtask

    task automatic test_unlock_relock();
        logic [31:0] w;
        logic [31:0] exp_vec [4] = '{32'hFFFF_FFFF, 32'hFFFF_FFF1, 32'hFFFF_FFF1, 32'hFFFF_FFF1};
        int lock_at = -1;
        pulse_clear();
        for (int i = 0; i < 4; i++) begin
            gen(w);
            drive(~w);
            checks++; if (err_vec !== exp_vec[i]) begin fails++; $display("FAIL unlock_err_vec%0d: got %h want %h", i, err_vec, exp_vec[i]); end
        end
        checks++; if (locked !== 1'b1) begin fails++; $display("FAIL unlock_still_locked: got %b want 1", locked); end
        idle(1);
        checks++; if (locked !== 1'b0) begin fails++; $display("FAIL unlock_dropped: got %b want 0", locked); end
        checks++; if (err_word_cnt !== 32'd4 || err_bit_cnt !== 32'd119) begin fails++; $display("FAIL unlock_counts: got %0d/%0d want 4/119", err_word_cnt, err_bit_cnt); end
        gen(w);
        drive(w);
        checks++; if (err_vec !== 32'h0000_000E) begin fails++; $display("FAIL recover_err_vec: got %h want 0000000e", err_vec); end
        for (int i = 1; i <= 16; i++) begin
            gen(w);
            drive(w);
            if (locked === 1'b1 && lock_at < 0) lock_at = i;
        end
        checks++; if (lock_at !== 16) begin fails++; $display("FAIL relock_word: got %0d want 16", lock_at); end
        pulse_clear();
        for (int i = 0; i < 64; i++) begin gen(w); drive(w); end
        gen(w);
        drive(w ^ 32'h8000_0000);
        idle(1);
        checks++; if (cw_err_cnt !== 32'd1) begin fails++; $display("FAIL relock_cw_index: got %0d want 1", cw_err_cnt); end
        for (int i = 0; i < 65; i++) begin gen(w); drive(w); end
        idle(1);
        checks++; if (cw_err_cnt !== 32'd1) begin fails++; $display("FAIL cw_mark_cleared: got %0d want 1", cw_err_cnt); end
    endtask

    task automatic test_gapped();
        logic [31:0] w;
        int sent = 0;
        int bad = 0;
        pulse_clear();
        while (sent < 130) begin
            if ($urandom_range(0, 1) == 1) begin
                gen(w);
                drive(w);
                sent++;
                if (err_valid !== 1'b1 || err_vec !== 32'd0) bad++;
            end else begin
                axis.tdata = $urandom;
                idle(1);
                if (err_valid !== 1'b0) bad++;
            end
        end
        idle(1);
        checks++; if (bad !== 0) begin fails++; $display("FAIL gapped_strobes: got %0d bad cycles want 0", bad); end
        checks++; if (word_cnt !== 48'd130) begin fails++; $display("FAIL gapped_word_cnt: got %0d want 130", word_cnt); end
        checks++; if ({err_word_cnt, err_bit_cnt, cw_err_cnt} !== '0 || locked !== 1'b1) begin fails++; $display("FAIL gapped_errors: got %h/%b want 0/1", {err_word_cnt, err_bit_cnt, cw_err_cnt}, locked); end
    endtask

    task automatic test_clear_and_reset();
        logic [31:0] w;
        gen(w);
        drive(w ^ 32'h1);
        clear_cnt = 1'b1;
        idle(1);
        clear_cnt = 1'b0;
        checks++; if ({word_cnt, err_word_cnt, err_bit_cnt} !== '0) begin fails++; $display("FAIL clear_beats_update: got %h want 0", {word_cnt, err_word_cnt, err_bit_cnt}); end
        gen(w);
        drive(w);
        idle(1);
        checks++; if (word_cnt !== 48'd1 || err_word_cnt !== 32'd1 || err_bit_cnt !== 32'd2) begin fails++; $display("FAIL after_clear: got %0d/%0d/%0d want 1/1/2", word_cnt, err_word_cnt, err_bit_cnt); end
        rst = 1'b1;
        gen(w);
        drive(w);
        drive(w);
        checks++; if ({word_cnt, err_word_cnt, err_bit_cnt, cw_err_cnt} !== '0 || {locked, err_valid, axis.tready} !== 3'b000) begin fails++; $display("FAIL midstream_reset: got %h/%b want 0/000", {word_cnt, err_word_cnt, err_bit_cnt, cw_err_cnt}, {locked, err_valid, axis.tready}); end
        rst = 1'b0;
        idle(1);
        gen(w);
        drive(w);
        checks++; if (err_valid !== 1'b0) begin fails++; $display("FAIL reseed_no_err_valid: got %b want 0", err_valid); end
        gen(w);
        drive(w);
        checks++; if (err_valid !== 1'b1 || err_vec !== 32'd0 || locked !== 1'b0) begin fails++; $display("FAIL reseed_check: got %b/%h/%b want 1/0/0", err_valid, err_vec, locked); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_clean_lock();
        test_early_bit();
        test_late_bit();
        test_unlock_relock();
        test_gapped();
        test_clear_and_reset();
        idle(2);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
